drain_serializer: RTL and testbench

Parametrised drain stage between the systolic array's per-column accumulator outputs and the narrow host/DMA output port. It buffers each column's accumulator words in a per-column FIFO. On `start` it drains all columns round-robin in column-interleaved order and serialises every word into `OUT_W`-bit beats under a valid/ready handshake. It flags the final beat and the end of the transfer. Column count, rows per column, element width, packing factor and output width are all generalised.

---
 rtl/drain_serializer_if.sv | 28 ++
 rtl/drain_serializer.sv | 200 ++++++++++++++++++++
 tb/tb_drain_serializer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drain_serializer_if.sv
// Bundle for the drain_serializer column write ports and the serial output beat stream.
// Beat handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
// while out_valid is high and out_ready low, out_data/out_last hold and out_valid stays high.
interface drain_serializer_if #(
  parameter int NUM_COLS = 4,
  parameter int W        = 32,
  parameter int OUT_W    = 8
);
  logic [NUM_COLS-1:0]   col_wr_en;
  logic [NUM_COLS*W-1:0] col_wr_data;
  logic [NUM_COLS-1:0]   col_full;
  logic                  out_ready;
  logic                  out_valid;
  logic [OUT_W-1:0]      out_data;
  logic                  out_last;

  // master: the serializer (consumes column writes, produces beats)
  modport master (
    input  col_wr_en, col_wr_data, out_ready,
    output col_full, out_valid, out_data, out_last
  );

  // slave: the environment (array columns and downstream host/DMA port)
  modport slave (
    output col_wr_en, col_wr_data, out_ready,
    input  col_full, out_valid, out_data, out_last
  );
endinterface

// File: rtl/drain_serializer.sv
// Per-column FWFT FIFOs drained round-robin into OUT_W-bit beats under valid/ready.
// Build option: DRAIN_SERIALIZER_MSB_FIRST_EN emits the most-significant slice of each word first.
module drain_serializer #(
  parameter int NUM_COLS     = 4,
  parameter int ROWS_PER_COL = 4,
  parameter int ELEM_W       = 16,
  parameter int ALPHA        = 2,
  parameter int OUT_W        = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  drain_serializer_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [1:0]          dbg_state
);

  localparam int W     = ALPHA * ELEM_W;
  localparam int BEATS = W / OUT_W;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int COLW  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ROWW  = (ROWS_PER_COL > 1) ? $clog2(ROWS_PER_COL) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [COLW-1:0] LAST_COL  = COLW'(NUM_COLS - 1);
  localparam logic [ROWW-1:0] LAST_ROW  = ROWW'(ROWS_PER_COL - 1);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);
  localparam bit              ONE_BEAT  = (BEATS == 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

  state_t              state;
  logic [W-1:0]        mem    [NUM_COLS][FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr [NUM_COLS];
  logic [AW-1:0]       rd_ptr [NUM_COLS];
  logic [CW-1:0]       cnt    [NUM_COLS];
  logic [W-1:0]        head   [NUM_COLS];
  logic [NUM_COLS-1:0] full_q, empty, pop, wr_ok;

  logic [COLW-1:0] col_idx, next_col;
  logic [ROWW-1:0] row_idx, next_row;
  logic [BW-1:0]   beat_cnt;
  logic [W-1:0]    word_q;
  logic            last_col, final_word, next_final, last_beat;

  assign bus.col_full = full_q;
  assign dbg_state    = state;

  function automatic logic [OUT_W-1:0] slice(input logic [W-1:0] w, input logic [BW-1:0] b);
    int sel;
`ifdef DRAIN_SERIALIZER_MSB_FIRST_EN
    sel = BEATS - 1 - int'(b);
`else
    sel = int'(b);
`endif
    return w[sel*OUT_W +: OUT_W];
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      empty[c] = (cnt[c] == '0);
      head[c]  = mem[c][rd_ptr[c]];
    end
  end

  always_comb begin
    last_col   = (col_idx == LAST_COL);
    next_col   = last_col ? '0 : col_idx + 1'b1;
    next_row   = last_col ? row_idx + 1'b1 : row_idx;
    final_word = last_col && (row_idx == LAST_ROW);
    next_final = (next_col == LAST_COL) && (next_row == LAST_ROW);
    last_beat  = (beat_cnt == LAST_BEAT);
  end

  // Pop on FETCH, or back-to-back on the last accepted beat when the next column already has data.
  always_comb begin
    pop = '0;
    if (state == S_FETCH && !empty[col_idx])
      pop[col_idx] = 1'b1;
    else if (state == S_EMIT && bus.out_ready && last_beat && !final_word && !empty[next_col])
      pop[next_col] = 1'b1;
  end

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++)
      wr_ok[c] = bus.col_wr_en[c] && (!full_q[c] || pop[c]);
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COLS; c++)
      if (wr_ok[c]) mem[c][wr_ptr[c]] <= bus.col_wr_data[c*W +: W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      full_q   <= '0;
      overflow <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (wr_ok[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])   rd_ptr[c] <= rd_ptr[c] + 1'b1;
        case ({wr_ok[c], pop[c]})
          2'b10: begin
            cnt[c]    <= cnt[c] + 1'b1;
            full_q[c] <= (cnt[c] == DEPTH_C - 1'b1);
          end
          2'b01: begin
            cnt[c]    <= cnt[c] - 1'b1;
            full_q[c] <= 1'b0;
          end
          default: ;
        endcase
        if (bus.col_wr_en[c] && !wr_ok[c]) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      col_idx       <= '0;
      row_idx       <= '0;
      beat_cnt      <= '0;
      word_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!empty[col_idx]) begin
            word_q        <= head[col_idx];
            beat_cnt      <= '0;
            bus.out_data  <= slice(head[col_idx], '0);
            bus.out_valid <= 1'b1;
            bus.out_last  <= final_word && ONE_BEAT;
            state         <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            if (!last_beat) begin
              beat_cnt     <= beat_cnt + 1'b1;
              bus.out_data <= slice(word_q, beat_cnt + 1'b1);
              bus.out_last <= final_word && (BW'(beat_cnt + 1'b1) == LAST_BEAT);
            end else if (final_word) begin
              state         <= S_DONE;
              done          <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.out_data  <= '0;
              col_idx       <= '0;
              row_idx       <= '0;
              beat_cnt      <= '0;
            end else begin
              col_idx  <= next_col;
              row_idx  <= next_row;
              beat_cnt <= '0;
              if (!empty[next_col]) begin
                word_q       <= head[next_col];
                bus.out_data <= slice(head[next_col], '0);
                bus.out_last <= next_final && ONE_BEAT;
              end else begin
                state         <= S_FETCH;
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drain_serializer.sv
// Directed bench for drain_serializer: default configuration plus a 3-column, 16-bit-beat instance.
module tb_drain_serializer;

  localparam int NC = 4, RP = 4, EW = 16, AL = 2, OW = 8, FD = 4;
  localparam int W = AL * EW, BEATS = W / OW, TOTAL = NC * RP * BEATS;
  localparam int NC2 = 3, W2 = 32, OW2 = 16, BEATS2 = 2, TOTAL2 = NC2 * 4 * BEATS2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start2 = 1'b0;
  logic busy, done, overflow, busy2, done2, overflow2;
  logic [1:0] dbg_state, dbg_state2;

  drain_serializer_if #(.NUM_COLS(NC),  .W(W),  .OUT_W(OW))  bus ();
  drain_serializer_if #(.NUM_COLS(NC2), .W(W2), .OUT_W(OW2)) bus2 ();

  drain_serializer #(.NUM_COLS(NC), .ROWS_PER_COL(RP), .ELEM_W(EW), .ALPHA(AL),
                     .OUT_W(OW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .overflow(overflow), .dbg_state(dbg_state));

  drain_serializer #(.NUM_COLS(NC2), .ROWS_PER_COL(4), .ELEM_W(8), .ALPHA(4),
                     .OUT_W(OW2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(bus2),
    .busy(busy2), .done(done2), .overflow(overflow2), .dbg_state(dbg_state2));

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [OW-1:0]  exp_q[$];
  logic [OW2-1:0] exp2_q[$];

  typedef struct {
    logic         en;
    logic [W-1:0] data;
    logic         exp_full;
    logic         exp_ovf;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] word_of(input int c, input int r);
    return {8'(c), 8'(r), 8'hA5, 8'h5A};
  endfunction

  task automatic push_word(input logic [W-1:0] w);
    int sel;
    for (int b = 0; b < BEATS; b++) begin
`ifdef DRAIN_SERIALIZER_MSB_FIRST_EN
      sel = BEATS - 1 - b;
`else
      sel = b;
`endif
      exp_q.push_back(w[sel*OW +: OW]);
    end
  endtask

  task automatic push_expected;
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < NC; c++)
        push_word(word_of(c, r));
  endtask

  // driver: one row per cycle across all columns, optionally skipping one column
  task automatic fill_rows(input int skip_col);
    for (int r = 0; r < RP; r++) begin
      for (int c = 0; c < NC; c++) begin
        bus.col_wr_en[c]          = (c != skip_col);
        bus.col_wr_data[c*W +: W] = word_of(c, r);
      end
      tick;
    end
    bus.col_wr_en = '0;
  endtask

  // mode 0: ready held high; 1: ready toggles per EMIT cycle; 2: ready high, gaps allowed
  task automatic drain(input int mode, input int exp_emit, input int exp_done_k, input string tag);
    int k = 0, beats = 0, emit = 0, first_k = -1, done_k = -1, idle_k = -1, gap = 0;
    logic [OW:0] held = '0;
    logic stalled = 1'b0;
    logic rdy;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 1;
    check({tag, "_busy_rise"}, busy, 1);
    while (k < 2000 && idle_k < 0) begin
      if (bus.out_valid) begin
        if (first_k < 0) first_k = k;
        if (stalled) check({tag, "_stall_hold"}, {bus.out_last, bus.out_data}, held);
        rdy = (mode == 1) ? (emit % 2 == 0) : 1'b1;
        emit++;
        bus.out_ready = rdy;
        if (rdy) begin
          if (exp_q.size() > 0) check({tag, "_beat"}, bus.out_data, exp_q.pop_front());
          else begin
            errors++;
            $display("FAIL %s_extra_beat: got %0h expected no beat", tag, bus.out_data);
          end
          check({tag, "_last"}, bus.out_last, (beats == TOTAL - 1));
          beats++;
          stalled = 1'b0;
        end else begin
          held    = {bus.out_last, bus.out_data};
          stalled = 1'b1;
        end
      end else begin
        bus.out_ready = (mode != 1);
        if (first_k >= 0 && beats < TOTAL) gap++;
      end
      if (done && done_k < 0) done_k = k;
      if (!busy && done_k >= 0) idle_k = k;
      tick;
      k++;
    end
    bus.out_ready = 1'b0;
    check({tag, "_finished"}, (idle_k >= 0), 1);
    check({tag, "_beats"}, beats, TOTAL);
    check({tag, "_first_valid"}, first_k, 2);
    check({tag, "_emit_cycles"}, emit, exp_emit);
    check({tag, "_busy_fall"}, idle_k, done_k + 1);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    if (exp_done_k >= 0) check({tag, "_done_cycle"}, done_k, exp_done_k);
    if (mode == 0) check({tag, "_no_bubble"}, gap, 0);
    if (mode == 2) check({tag, "_gap_seen"}, (gap > 0), 1);
  endtask

  initial begin
    int n;
    logic [OW2-1:0] b0, b1, got;

    vt[0] = '{1'b1, word_of(1, 0), 1'b0, 1'b0};
    vt[1] = '{1'b1, word_of(1, 1), 1'b0, 1'b0};
    vt[2] = '{1'b1, word_of(1, 2), 1'b0, 1'b0};
    vt[3] = '{1'b1, word_of(1, 3), 1'b1, 1'b0};
    vt[4] = '{1'b1, 32'hDEADBEEF,  1'b1, 1'b1};
    vt[5] = '{1'b0, 32'h0,         1'b1, 1'b1};

    bus.col_wr_en = '0;  bus.col_wr_data = '0;  bus.out_ready = 1'b0;
    bus2.col_wr_en = '0; bus2.col_wr_data = '0; bus2.out_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    tick;

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_col_full", bus.col_full, 0);

    fill_rows(-1);
    push_expected();
    drain(0, TOTAL, 2 + TOTAL, "basic");

    fill_rows(-1);
    push_expected();
    drain(1, 2 * TOTAL - 1, 2 + 2 * TOTAL - 1, "toggle");

    fill_rows(2);
    push_expected();
    fork
      drain(2, TOTAL, -1, "gap");
      begin
        repeat (10) tick;
        for (int r = 0; r < RP; r++) begin
          bus.col_wr_en[2]          = 1'b1;
          bus.col_wr_data[2*W +: W] = word_of(2, r);
          tick;
        end
        bus.col_wr_en = '0;
      end
    join

    for (int i = 0; i < 6; i++) begin
      bus.col_wr_en[1]          = vt[i].en;
      bus.col_wr_data[1*W +: W] = vt[i].data;
      tick;
      check("ovf_col_full", bus.col_full, {2'b00, vt[i].exp_full, 1'b0});
      check("ovf_sticky", overflow, vt[i].exp_ovf);
    end
    fill_rows(1);
    push_expected();
    drain(0, TOTAL, 2 + TOTAL, "after_ovf");
    check("after_ovf_col_full", bus.col_full, 0);

    fill_rows(-1);
    push_expected();
    start = 1'b1;
    tick;
    start = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 200 && n < 20; k++) begin
      if (bus.out_valid) n++;
      tick;
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_last", bus.out_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_col_full", bus.col_full, 0);
    bus.out_ready = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    exp_q.delete();
    fill_rows(-1);
    push_expected();
    drain(0, TOTAL, 2 + TOTAL, "post_rst");

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NC2; c++) begin
        logic [W2-1:0] w;
        w = (c == 0 && r == 0) ? 32'h11223344 : {8'(c), 8'(r), 16'hA55A};
        bus2.col_wr_en[c]            = 1'b1;
        bus2.col_wr_data[c*W2 +: W2] = w;
`ifdef DRAIN_SERIALIZER_MSB_FIRST_EN
        exp2_q.push_back(w[31:16]);
        exp2_q.push_back(w[15:0]);
`else
        exp2_q.push_back(w[15:0]);
        exp2_q.push_back(w[31:16]);
`endif
      end
      tick;
    end
    bus2.col_wr_en = '0;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    bus2.out_ready = 1'b1;
    n = 0; b0 = '0; b1 = '0;
    for (int k = 0; k < 200 && !done2; k++) begin
      if (bus2.out_valid) begin
        got = bus2.out_data;
        if (n == 0) b0 = got;
        if (n == 1) b1 = got;
        if (exp2_q.size() > 0) check("w2_beat", got, exp2_q.pop_front());
        else begin
          errors++;
          $display("FAIL w2_extra_beat: got %0h expected no beat", got);
        end
        check("w2_last", bus2.out_last, (n == TOTAL2 - 1));
        n++;
      end
      tick;
    end
    check("w2_count", n, TOTAL2);
    check("w2_done", done2, 1);
`ifdef DRAIN_SERIALIZER_MSB_FIRST_EN
    check("w2_first_beat", b0, 16'h1122);
    check("w2_second_beat", b1, 16'h3344);
`else
    check("w2_first_beat", b0, 16'h3344);
    check("w2_second_beat", b1, 16'h1122);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
